nios_dut_mem_loader: RTL
========================

# nios_dut_mem_loader

Avalon-MM write master that loads the NIOS DUT on-chip program memory (2048 × 32, single port, byte-enabled) from an 8-bit byte stream, then reads the loaded region back to verify it. It sits directly upstream of the on-chip memory slave and drives its `address`/`byteenable`/`chipselect`/`write`/`writedata` and samples its `readdata`. A host-side stream source (UART/JTAG bridge) feeds it. It reports a 16-bit byte checksum plus a done/error status.

## Interface
Parameters:
- `ADDR_W`, 11: word address width; matches the 2048-word memory.
- `COUNT_W`, 13: byte count width; up to 8191 bytes.

Ports:
- **Clock/reset (already decided):** one clock, `clk`; `reset` is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load. Ignored while `busy`=1.
- `base_addr`  in  ADDR_W  first word address; sampled on accepted `start`.
- `byte_count`  in  COUNT_W  number of bytes to load; sampled on accepted `start`.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_address`  out  ADDR_W  memory word address.
- `mem_byteenable`  out  4  byte lanes to write.
- `mem_chipselect`  out  1  memory access strobe.
- `mem_write`  out  1  write strobe; qualified by `mem_chipselect`.
- `mem_writedata`  out  32  packed word.
- `mem_readdata`  in  32  memory read data.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of load and verify.
- `error`  out  1  verify mismatch. Sticky; cleared on the next accepted `start`.
- `checksum`  out  16  mod-2^16 sum of all bytes accepted. Valid when `done`=1; held until the next `start`.

The memory's `clken` and `reset_req` are tied to 1 and 0 at the top level.

## Operation
- **States:** IDLE, FILL, WRITE, VADDR, VDATA, DONE.
- **IDLE, on `start`:**
  - Latch `base_addr` and `byte_count`.
  - Clear `checksum`, `error`, lane index and the verify sum.
  - Go to DONE if `byte_count`=0, otherwise go to FILL.
- **FILL:**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&`in_ready`) is placed in lane k mod 4, bits [8k+7:8k], little-endian.
  - Set that lane's byteenable bit, add the byte to `checksum`, and decrement the remaining count.
  - Go to WRITE when lane 3 is filled or the remaining count reaches 0.
- **WRITE:**
  - `in_ready`=0.
  - `mem_chipselect`=`mem_write`=1 for exactly one cycle, with the address, packed data and byteenable.
  - Then increment the address, clear the lanes, and go to FILL, or to VADDR if no bytes remain.
  - A final partial word writes only the filled lanes (e.g. 2 bytes gives byteenable 4'b0011). Unfilled lanes of `mem_writedata` are 0.
- **Address arithmetic:** ADDR_W-bit, wrapping 2^ADDR_W−1 → 0. The byte count itself is never truncated.
- **VADDR:**
  - Reload the address from the latched base and the remaining count from the latched `byte_count`.
  - Drive `mem_chipselect`=1, `mem_write`=0.
- **VDATA:**
  - Sample `mem_readdata` and add the bytes in the lanes that were written for this word (min(4, remaining) lowest lanes) to the verify sum.
  - Decrement the remaining count by that amount and increment the address.
  - Go to VADDR if bytes remain, otherwise go to DONE.
- **DONE:**
  - `done`=1 for one cycle.
  - `error` is set if verify sum ≠ `checksum`.
  - Go to IDLE.
- **Reset:** all outputs are 0, state is IDLE, and a partial word is discarded. Reset mid-load aborts with no further memory access. No `done` pulse is generated.
- `start` asserted in any non-IDLE state has no effect.

## Timing
- Memory read latency is 1 cycle: the address is registered inside the RAM and `q` is unregistered. The value driven in VADDR is read in VDATA.
- **Load throughput:** 4 accept cycles + 1 WRITE cycle per full word, given continuous `in_valid`. `in_valid` gaps only stall FILL.
- **Verify:** 2 cycles per word.
- **Zero-length load:** `start` at cycle 0 gives `done` at cycle 1 and `busy`=1 in cycle 1 only.
- **General load:** `done` occurs 1 cycle after the last VDATA. `busy` falls together with `done`.
- Memory outputs are registered; no combinational path from `in_valid` to the `mem_*` outputs.

## Test plan
- **Full words:** base 0x000, count 8, bytes 01..08.
  - Writes addr 0x000 data 0x04030201 be 0xF, then addr 0x001 data 0x08070605 be 0xF.
  - `checksum`=0x0024, `done` pulse, `error`=0.
- **Wrap and partial word:** base 0x7FF, count 6, bytes 0xA0..0xA5.
  - Writes addr 0x7FF data 0xA3A2A1A0 be 0xF, then addr 0x000 data 0x0000A5A4 be 0x3.
  - Verify reads 0x7FF then 0x000; `error`=0.
- **Zero length:** count 0 → `done` in the next cycle, no `mem_chipselect`, `checksum`=0.
- **Corrupted readback:** memory model flips bit 0 of addr 0x001 after the write → `error`=1 at `done`. The next `start` clears `error`.
- **Backpressure and ignored start:** random `in_valid` gaps.
  - `in_ready`=0 in every WRITE cycle and no byte is lost.
  - A `start` pulse during FILL changes nothing.
- **Reset mid-operation:** reset after 3 bytes → no write issued, all outputs 0. A fresh `start` then loads correctly.

Source files
------------

// File: rtl/nios_dut_mem_loader.sv
// Avalon-MM loader for the NIOS DUT program memory: packs an 8-bit stream into
// byte-enabled 32-bit writes, then reads the region back and compares byte sums.
module nios_dut_mem_loader #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned COUNT_W = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] byte_count,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [3:0]         mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [31:0]        mem_writedata,
  input  logic [31:0]        mem_readdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_VADDR = 3'd3,
    S_VDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  base_q,  base_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [COUNT_W-1:0] rem_q,   rem_d;
  logic [1:0]         lane_q,  lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q,    be_d;
  logic [15:0]        csum_q,  csum_d;
  logic [15:0]        vsum_q,  vsum_d;
  logic               err_q,   err_d;
  logic               ready_q, ready_d;
  logic               cs_q,    cs_d;
  logic               wr_q,    wr_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               accept;
  logic [15:0]        vsum_add;
  logic [COUNT_W-1:0] vtake;

  // in_ready is a registered decode of FILL, so acceptance never sees a stale state
  assign accept = in_valid & ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (byte_count == '0) ? S_DONE : S_FILL;
      S_FILL:  if (accept && (lane_q == 2'd3 || rem_q == COUNT_W'(1))) state_d = S_WRITE;
      S_WRITE: state_d = (rem_q == '0) ? S_VADDR : S_FILL;
      S_VADDR: state_d = S_VDATA;
      S_VDATA: state_d = (rem_q <= COUNT_W'(4)) ? S_DONE : S_VADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    base_d   = base_q;
    count_d  = count_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    csum_d   = csum_q;
    vsum_d   = vsum_q;
    err_d    = err_q;
    vsum_add = '0;
    vtake    = (rem_q > COUNT_W'(4)) ? COUNT_W'(4) : rem_q;

    for (int i = 0; i < 4; i++) begin
      if (COUNT_W'(i) < rem_q) vsum_add = vsum_add + 16'(mem_readdata[8*i +: 8]);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = byte_count;
          addr_d  = base_addr;
          rem_d   = byte_count;
          lane_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          csum_d  = '0;
          vsum_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (accept) begin
          wdata_d[{lane_q, 3'b000} +: 8] = in_data;
          be_d[lane_q] = 1'b1;
          csum_d = csum_q + 16'(in_data);
          rem_d  = rem_q - COUNT_W'(1);
          lane_d = lane_q + 2'd1;
        end
      end
      S_WRITE: begin
        wdata_d = '0;
        be_d    = '0;
        lane_d  = '0;
        // Last word written: rewind to the base for the readback pass
        if (rem_q == '0) begin
          addr_d = base_q;
          rem_d  = count_q;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_VDATA: begin
        vsum_d = vsum_q + vsum_add;
        rem_d  = rem_q - vtake;
        addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase

    if (state_d == S_DONE && vsum_d != csum_d) err_d = 1'b1;

    ready_d = (state_d == S_FILL);
    cs_d    = (state_d == S_WRITE) || (state_d == S_VADDR);
    wr_d    = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      csum_q  <= '0;
      vsum_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      csum_q  <= csum_d;
      vsum_q  <= vsum_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready       = ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign checksum       = csum_q;

endmodule
